// File: rtl/vx_decode_pkg.sv
// vx_decode_pkg: decode payload layout shared by the decode queue and its users.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef EX_BITS
`define EX_BITS 3
`endif
`ifndef INST_OP_BITS
`define INST_OP_BITS 4
`endif
`ifndef INST_MOD_BITS
`define INST_MOD_BITS 3
`endif
`ifndef NR_BITS
`define NR_BITS 6
`endif

package vx_decode_pkg;
    localparam int VX_NUM_WARPS  = `NUM_WARPS;
    localparam int NW_BITS       = (VX_NUM_WARPS > 1) ? $clog2(VX_NUM_WARPS) : 1;
    localparam int UUID_W        = `UUID_WIDTH;
    localparam int NUM_THREADS   = `NUM_THREADS;
    localparam int EX_BITS       = `EX_BITS;
    localparam int INST_OP_BITS  = `INST_OP_BITS;
    localparam int INST_MOD_BITS = `INST_MOD_BITS;
    localparam int NR_BITS       = `NR_BITS;

    typedef struct packed {
        logic [UUID_W-1:0]        uuid;
        logic [NW_BITS-1:0]       wid;
        logic [NUM_THREADS-1:0]   tmask;
        logic [31:0]              PC;
        logic [EX_BITS-1:0]       ex_type;
        logic [INST_OP_BITS-1:0]  op_type;
        logic [INST_MOD_BITS-1:0] op_mod;
        logic                     wb;
        logic                     use_PC;
        logic                     use_imm;
        logic [31:0]              imm;
        logic [NR_BITS-1:0]       rd;
        logic [NR_BITS-1:0]       rs1;
        logic [NR_BITS-1:0]       rs2;
        logic [NR_BITS-1:0]       rs3;
    } decode_data_t;

    localparam int VX_DECODE_DATAW = $bits(decode_data_t);
    localparam int WID_LSB         = VX_DECODE_DATAW - UUID_W - NW_BITS;

    function automatic logic [NW_BITS-1:0] get_wid(input logic [VX_DECODE_DATAW-1:0] d);
        return d[WID_LSB +: NW_BITS];
    endfunction
endpackage

// File: rtl/vx_decode_fifo_mem.sv
// vx_decode_fifo_mem: DEPTH x DATAW register array, one write port, async read port.
module vx_decode_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int DATAW = 8
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DATAW-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [DATAW-1:0]         o_rd_data
);
    logic [DATAW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/vx_decode_queue.sv
// vx_decode_queue: in-order decode-to-issue FIFO with per-warp occupancy tracking.
module vx_decode_queue
    import vx_decode_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int NUM_WARPS = `NUM_WARPS,
    parameter int DATAW     = VX_DECODE_DATAW
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     dec_valid,
    input  logic [DATAW-1:0]         dec_data,
    output logic                     dec_ready,
    output logic                     iss_valid,
    output logic [DATAW-1:0]         iss_data,
    input  logic                     iss_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [NUM_WARPS-1:0]     wid_pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      r_wcnt [NUM_WARPS];
    logic               w_push, w_pop;
    logic [NW_BITS-1:0] w_push_wid, w_pop_wid;

    // Handshake flags come only from registered count, so no pass-through paths exist.
    assign dec_ready  = r_count != CW'(DEPTH);
    assign iss_valid  = r_count != '0;
    assign count      = r_count;
    assign w_push     = dec_valid && dec_ready;
    assign w_pop      = iss_valid && iss_ready;
    assign w_push_wid = get_wid(dec_data);
    assign w_pop_wid  = get_wid(iss_data);

    vx_decode_fifo_mem #(.DEPTH(DEPTH), .DATAW(DATAW)) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (dec_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (iss_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_wcnt
        logic w_inc, w_dec;
        assign w_inc = w_push && (w_push_wid == NW_BITS'(g));
        assign w_dec = w_pop && (w_pop_wid == NW_BITS'(g));
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) r_wcnt[g] <= '0;
            else          r_wcnt[g] <= r_wcnt[g] + CW'(w_inc) - CW'(w_dec);
        end
        assign wid_pending[g] = r_wcnt[g] != '0;
    end

    logic [31:0] w_wsum;
    always_comb begin
        w_wsum = '0;
        for (int i = 0; i < NUM_WARPS; i++) w_wsum = w_wsum + 32'(r_wcnt[i]);
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (!reset_n) !(w_push && r_count == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n) !(w_pop && r_count == '0));
    a_wcnt_sum:     assert property (@(posedge clk) disable iff (!reset_n) w_wsum == 32'(r_count));
endmodule

// File: doc/vx_decode_queue.md
Name: vx_decode_queue

Overview:
- Receiving (slave) end of the decode interface: accepts decoded instructions on a valid/ready handshake and stores them in a DEPTH-entry in-order FIFO.
- Re-presents each stored instruction, unchanged and in arrival order, on an issue-side valid/ready port.
- Sits between the decode stage and the scoreboard/dispatch logic.
- Tracks per-warp occupancy so the warp scheduler can see which warps have instructions in flight.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- NUM_WARPS, `NUM_WARPS, number of warps; sets the per-warp counter array size.
- DATAW, VX_DECODE_DATAW (package), packed payload width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decode side: instruction valid.
- dec_data  in  DATAW  decode side: packed payload.
- dec_ready  out  1  decode side: queue can accept.
- iss_valid  out  1  issue side: head entry valid.
- iss_data  out  DATAW  issue side: head entry payload.
- iss_ready  in  1  issue side: consumer accepts head.
- count  out  $clog2(DEPTH)+1  current occupancy.
- wid_pending  out  NUM_WARPS  bit w set when the queue holds any instruction of warp w.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, reset_n).
- Payload packing, MSB to LSB: uuid, wid, tmask, PC, ex_type, op_type, op_mod, wb, use_PC, use_imm, imm, rd, rs1, rs2, rs3. Widths come from the UUID/NW/NUM_THREADS/EX/INST_OP/INST_MOD/NR_BITS macros.
- Push when dec_valid && dec_ready. Pop when iss_valid && iss_ready.
- dec_ready = (count != DEPTH). It is combinational from registered count only and never depends on iss_ready, so there is no full-queue pass-through.
- iss_valid = (count != 0). iss_data = mem[rd_ptr], with no combinational path from dec_data.
- Latency: an instruction pushed at edge N is visible on iss_valid/iss_data after edge N (1 cycle minimum). There is no bypass.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. count updates +1 on push only, -1 on pop only, and is unchanged on simultaneous push and pop.
- Simultaneous push and pop at count==1: the old head leaves and the new entry becomes head on the next cycle; iss_valid stays 1.
- Simultaneous push and pop at count==0 cannot occur.
- Per-warp counters: wcnt[w] is $clog2(DEPTH)+1 bits.
  - Increment on push when dec_data.wid==w.
  - Decrement on pop when iss_data.wid==w.
  - Same-warp push and pop in one cycle leaves wcnt[w] unchanged.
  - wid_pending[w] = (wcnt[w] != 0).
- Data retention: iss_data holds stable while iss_valid && !iss_ready. Inputs are ignored when dec_ready==0.
- Reset (asynchronous, any time, including mid-transfer): rd_ptr=0, wr_ptr=0, count=0, all wcnt=0.
  - Outputs during and after reset: iss_valid=0, dec_ready=1, wid_pending=0.
  - Storage contents are not reset; iss_data is don't-care while iss_valid=0.
- Assertions (simulation only):
  - no push when count==DEPTH;
  - no pop when count==0;
  - sum of wcnt equals count.

Decomposition:
- Package vx_decode_pkg holds:
  - VX_DECODE_DATAW;
  - a packed struct decode_data_t with the field order above;
  - field offset constants used by the counter logic to extract wid.
- One natural sub-module, vx_decode_fifo_mem: DEPTH x DATAW register array with a write port (en, addr, data) and an asynchronous read port. Pointers, counters and handshake logic stay in the top.

Test Plan (DEPTH=4, NUM_WARPS=4):
- Reset then idle -> dec_ready=1, iss_valid=0, count=0, wid_pending=4'b0000.
- Push wid=2, PC=0x80000000 with iss_ready=0 -> next cycle iss_valid=1, iss_data.PC=0x80000000, count=1, wid_pending=4'b0100.
- Push 4 entries (wid 0,1,1,3) with iss_ready=0 -> count=4, dec_ready=0, wid_pending=4'b1011. A fifth dec_valid is not accepted and count stays 4.
- Full queue, then iss_ready=1 for 4 cycles with dec_valid=0 -> entries pop in order wid 0,1,1,3. wid_pending steps 1011 -> 1010 -> 1010 -> 1000 -> 0000. dec_ready=1 from the cycle after the first pop.
- Streaming: dec_valid=1 and iss_ready=1 continuously for 10 instructions with PC 0x100..0x124 step 4 -> count stays 1 after the first cycle, output PCs in order, wrap-around of pointers is exercised, no loss or duplication.
- Assert reset_n=0 asynchronously mid-stream with count=3 -> iss_valid=0, count=0, wid_pending=0 immediately, without waiting for a clock edge. After release, the first push appears intact on the following cycle.
